// File: rtl/fa4_mbit_adder.sv
// Registered 4-bit adder with two independent sum paths (ripple-carry and
// vector add). The vector result is delivered; disagreement raises mismatch.

module fa4_fa_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module fa4_mbit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             out_valid,
  output logic             mismatch
);
  localparam int STAGES = 1;

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s_rc;
  logic [WIDTH:0]   w_sum_m;
  logic             w_mm;

  logic [STAGES:1]  r_vld_pipe;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_mm;

  // Structural path: one full-adder slice per bit, carry rippling upward.
  assign w_c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    fa4_fa_slice u_slice (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_c[i]),
      .o_s (w_s_rc[i]),
      .o_c (w_c[i+1])
    );
  end

  assign w_sum_m = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign w_mm    = ({w_c[WIDTH], w_s_rc} != w_sum_m);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s        <= '0;
      r_co       <= 1'b0;
      r_mm       <= 1'b0;
    end else begin
      r_vld_pipe <= STAGES'(in_valid);
      if (in_valid) begin
        r_s  <= w_sum_m[WIDTH-1:0];
        r_co <= w_sum_m[WIDTH];
        r_mm <= w_mm;
      end
    end
  end

  assign s         = r_s;
  assign co        = r_co;
  assign out_valid = r_vld_pipe[STAGES];
  assign mismatch  = r_mm;
endmodule

// File: tb/tb_fa4_mbit_adder.sv
// Randomized/directed bench for fa4_mbit_adder against an arithmetic model.

module tb_fa4_mbit_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic       ci;
  logic [3:0] s;
  logic       co, out_valid, mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: what the outputs must show after the most recent edge
  int exp_s, exp_co, exp_vld;

  always #5 clk = ~clk;

  fa4_mbit_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .s         (s),
    .co        (co),
    .out_valid (out_valid),
    .mismatch  (mismatch)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // drive at negedge, let the edge happen, update model, check #1 later
  task automatic step(input string tag, input bit rst, input bit v,
                      input int ia, input int ib, input int ic);
    int sum;
    @(negedge clk);
    rst_n = ~rst; in_valid = v; a = 4'(ia); b = 4'(ib); ci = 1'(ic);
    @(posedge clk);
    if (rst) begin
      exp_s = 0; exp_co = 0; exp_vld = 0;
    end else begin
      exp_vld = v;
      if (v) begin
        sum    = ia + ib + ic;
        exp_s  = sum % 16;
        exp_co = sum / 16;
      end
    end
    #1;
    chk({tag, ".s"},   int'(s),         exp_s);
    chk({tag, ".co"},  int'(co),        exp_co);
    chk({tag, ".vld"}, int'(out_valid), exp_vld);
    chk({tag, ".mm"},  int'(mismatch),  0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
    exp_s = 0; exp_co = 0; exp_vld = 0;

    step("rst0", 1, 1, 15, 15, 1);
    step("rst1", 1, 1, 15, 15, 1);

    step("max",    0, 1, 15, 15, 1);
    step("rip_a",  0, 1, 9, 7, 0);
    step("rip_b",  0, 1, 15, 0, 1);
    step("nocy_a", 0, 1, 5, 3, 1);
    step("nocy_b", 0, 1, 0, 0, 0);
    step("pre",    0, 1, 12, 7, 1);
    step("hold0",  0, 0, 3, 3, 0);
    step("hold1",  0, 0, 15, 15, 1);
    step("str0",   0, 1, 1, 2, 0);
    step("str1",   0, 1, 8, 8, 1);
    step("str2",   0, 1, 14, 13, 0);
    step("idle",   0, 0, 0, 0, 0);

    // reset with valid input must drop it; next valid edge gives first result
    step("rstv",   1, 1, 7, 9, 1);
    step("postr",  0, 0, 7, 9, 1);
    step("first",  0, 1, 6, 6, 1);

    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          step("exh", 0, 1, x, y, c);

    for (int k = 0; k < 1000; k++)
      step("rnd", 0, ($urandom_range(3) != 0), $urandom_range(15),
           $urandom_range(15), $urandom_range(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fa4_mbit_adder.md
FA4_MBIT_ADDER -- requirements
Module: fa4_mbit_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; 4 is the only supported value.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: in_valid  input  1  high = a/b/ci sampled this cycle.
REQ-005 Port: a  input  4  addend, unsigned.
REQ-006 Port: b  input  4  addend, unsigned.
REQ-007 Port: ci  input  1  carry-in.
REQ-008 Port: s  output  4  registered sum, low 4 bits of a+b+ci.
REQ-009 Port: co  output  1  registered carry-out, bit 4 of a+b+ci.
REQ-010 Port: out_valid  output  1  high for one cycle when s/co hold a new result.
REQ-011 Port: mismatch  output  1  registered self-check flag; high if the two internal adder paths disagree.

Function
REQ-012 Two independent combinational adders SHALL compute the same sum from a, b, ci.
REQ-013 The structural path SHALL be a 4-slice ripple-carry chain of 1-bit full adders.
- Slice i: s_i = a_i ^ b_i ^ c_i.
- Slice i: c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
- c_0 = ci; the carry-out of this path is c_4.
REQ-014 The multi-bit path SHALL be a single 5-bit vector addition: {co_m, s_m} = a + b + ci, zero-extended.
REQ-015 Arithmetic SHALL be unsigned modulo 32 on {co, s}; the result range is 0..31 and no overflow is lost.
REQ-016 On a rising edge with rst_n=1 and in_valid=1:
- s and co SHALL load the multi-bit path result;
- out_valid SHALL be 1;
- mismatch SHALL be 1 if {c_4, s_rc} != {co_m, s_m}, else 0.
REQ-017 On a rising edge with rst_n=1 and in_valid=0:
- s, co and mismatch SHALL hold their values;
- out_valid SHALL be 0.
REQ-018 Latency SHALL be exactly one clock from the sampling edge to the outputs; back-to-back in_valid SHALL yield one result per cycle with no bubbles.
REQ-019 The design SHALL contain no combinational path from inputs to outputs.
REQ-020 For all 512 input combinations of {ci, a, b}, the two paths SHALL agree, so mismatch SHALL never assert in correct hardware.

Reset
REQ-021 When rst_n=0 at a rising edge, the following SHALL be cleared to 0 regardless of in_valid:
- s = 0;
- co = 0;
- out_valid = 0;
- mismatch = 0.
REQ-022 Reset asserted while in_valid=1 SHALL discard that input; the first result after reset SHALL come from the first in_valid=1 edge with rst_n=1.
REQ-023 Output values before the first clock edge with rst_n=0 are unspecified.

Verification
REQ-024 Reset: hold rst_n=0 with in_valid=1, a=15, b=15, ci=1 -> s=0, co=0, out_valid=0, mismatch=0.
REQ-025 Max value: a=15, b=15, ci=1, in_valid=1 -> next cycle s=15, co=1, out_valid=1, mismatch=0.
REQ-026 Carry ripple: a=9, b=7, ci=0 -> s=0, co=1. Also a=15, b=0, ci=1 -> s=0, co=1.
REQ-027 No carry: a=5, b=3, ci=1 -> s=9, co=0. Also a=0, b=0, ci=0 -> s=0, co=0.
REQ-028 Hold and streaming:
- in_valid=0 after a result -> s/co unchanged, out_valid=0.
- Three consecutive valid inputs -> three consecutive out_valid pulses with matching sums.
REQ-029 Exhaustive check: sweep all 512 {ci, a, b} combinations, plus 1000 random vectors. For each:
- {co, s} SHALL equal a+b+ci one cycle later;
- mismatch SHALL stay 0 throughout.
